// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: the controller state encoding,
// the idle line level and the default bit period (48 MHz clock, 9600 bps).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE            = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 5000;

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period divider. It counts only while enabled, and it emits a
// one-cycle tick on the last clock of each bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST);

    // NOTE: tick is decoded from the registered count, so the controller sees it
    // on the same edge where the counter wraps. No extra cycle is added per bit.
    assign tick = enable && !restart && w_at_last;

    // NOTE: sequential state uses non-blocking assignments only. Reset is
    // asynchronous, so it is listed in the sensitivity list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (restart) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start bit, DATA_BITS LSB first, optional even parity,
// then STOP_BITS stop bits. Parity is built in only when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               IDX_W     = $clog2(DATA_BITS) + 1;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_serial;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_accept;
    logic w_tick;

    assign w_accept = tx_valid && r_ready;

    // Restarting on the accept edge aligns every frame to its own start bit.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(w_accept),
        .enable (r_busy),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_serial  <= LINE_IDLE;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift   <= tx_data;
                        r_bit_idx <= '0;
                        r_serial  <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= START;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^tx_data;
`endif
                    end
                end

                START: begin
                    if (w_tick) begin
                        r_serial <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_state  <= DATA;
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_DATA) begin
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_serial  <= r_parity;
                            r_state   <= PARITY;
`else
                            r_serial  <= LINE_IDLE;
                            r_state   <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_serial  <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_serial <= LINE_IDLE;
                        r_state  <= STOP;
                    end
                end
`endif

                // The stop period is counted in whole bit ticks, using the freed bit index.
                STOP: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_STOP) begin
                            r_bit_idx <= '0;
                            r_done    <= 1'b1;
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    r_bit_idx <= '0;
                    r_serial  <= LINE_IDLE;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready  = r_ready;
    assign tx_serial = r_serial;
    assign tx_busy   = r_busy;
    assign tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: instance A has one stop bit and instance B has two.
// Both use CLKS_PER_BIT=8, and the expected frame lengths follow UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;

    localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int HAS_PAR = 1;
    localparam int DONE_A  = 88;   // tx_done in the 89th cycle after accept
    localparam int DONE_B  = 96;
`else
    localparam int HAS_PAR = 0;
    localparam int DONE_A  = 80;   // tx_done in the 81st cycle after accept
    localparam int DONE_B  = 88;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       valid_a, valid_b;
    logic       ready_a, serial_a, busy_a, done_a;
    logic       ready_b, serial_b, busy_b, done_b;
    logic       sel;
    logic       m_ready, m_serial, m_busy, m_done;

    int total = 0;
    int bad   = 0;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (valid_a),
        .tx_ready (ready_a),
        .tx_serial(serial_a),
        .tx_busy  (busy_a),
        .tx_done  (done_a)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (valid_b),
        .tx_ready (ready_b),
        .tx_serial(serial_b),
        .tx_busy  (busy_b),
        .tx_done  (done_b)
    );

    assign m_ready  = sel ? ready_b  : ready_a;
    assign m_serial = sel ? serial_b : serial_a;
    assign m_busy   = sel ? busy_b   : busy_a;
    assign m_done   = sel ? done_b   : done_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         done_edge;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) valid_b = v;
        else     valid_a = v;
    endtask

    task automatic wait_ready(input string name);
        int w = 0;
        while (m_ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check(name, m_ready, 1);
    endtask

    // Sends one byte and checks every line cycle up to the tx_done cycle.
    // Sample n is taken on the negedge after posedge n, counted from the accept edge (n = 0).
    task automatic send_frame(input logic [7:0] d, input logic par, input int done_edge,
                              input logic disturb);
        int   b;
        logic exp_bit;
        logic ok;
        wait_ready($sformatf("ready_before_%02h", d));
        @(negedge clk);
        tx_data = d;
        set_valid(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_valid(1'b0);
        tx_data = ~d;
        ok = 1'b1;
        for (int n = 0; n < done_edge; n++) begin
            b = n / CPB;
            if (b == 0)                     exp_bit = 1'b0;
            else if (b <= 8)                exp_bit = d[b-1];
            else if (HAS_PAR == 1 && b == 9) exp_bit = par;
            else                            exp_bit = 1'b1;
            if (disturb && n == 26) begin
                tx_data = 8'h3C;
                set_valid(1'b1);
            end
            if (disturb && n == 27) set_valid(1'b0);
            if (m_serial !== exp_bit || m_busy !== 1'b1 || m_ready !== 1'b0 || m_done !== 1'b0)
                ok = 1'b0;
            if (n % CPB == CPB - 1) begin
                check($sformatf("frame_%02h_bit%0d", d, b), ok, 1);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        check($sformatf("done_%02h", d), m_done, 1);
        check($sformatf("ready_at_done_%02h", d), m_ready, 1);
        check($sformatf("idle_line_%02h", d), {m_busy, m_serial}, 2'b01);
        @(negedge clk);
        check($sformatf("done_single_%02h", d), m_done, 0);
    endtask

    initial begin
        int   fall;
        int   done_n;
        logic prev;
        logic ok;

        vecs[0] = '{data: 8'hA5, par: 1'b0, done_edge: DONE_A};
        vecs[1] = '{data: 8'h07, par: 1'b1, done_edge: DONE_A};
        vecs[2] = '{data: 8'h00, par: 1'b0, done_edge: DONE_A};
        vecs[3] = '{data: 8'hFF, par: 1'b0, done_edge: DONE_A};
        vecs[4] = '{data: 8'h80, par: 1'b1, done_edge: DONE_A};

        sel     = 1'b0;
        tx_data = 8'h00;
        valid_a = 1'b0;
        valid_b = 1'b0;
        reset   = 1'b1;
        #1;
        check("reset_outputs_a", {ready_a, serial_a, busy_a, done_a}, 4'b1100);
        check("reset_outputs_b", {ready_b, serial_b, busy_b, done_b}, 4'b1100);
        // A handshake offered during reset must not be taken.
        valid_a = 1'b1;
        repeat (3) @(negedge clk);
        check("no_accept_in_reset", {ready_a, busy_a, serial_a}, 3'b101);
        valid_a = 1'b0;
        reset   = 1'b0;

        for (int i = 0; i < 5; i++)
            send_frame(vecs[i].data, vecs[i].par, vecs[i].done_edge, 1'b0);

        // Back-to-back frames with valid held high.
        wait_ready("b2b_ready_start");
        @(negedge clk);
        tx_data = 8'h00;
        valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        fall = -1;
        prev = 1'b0;
        ok   = 1'b1;
        for (int n = 0; n <= 100; n++) begin
            if (n < DONE_A && m_ready !== 1'b0) ok = 1'b0;
            if (n == DONE_A) begin
                check("b2b_done", m_done, 1);
                check("b2b_ready_idle", m_ready, 1);
            end
            if (fall < 0 && n > 0 && prev && !m_serial) begin
                fall    = n;
                valid_a = 1'b0;
            end
            prev = m_serial;
            if (n == DONE_A + 1 + 12) check("b2b_second_bit0", m_serial, 1);
            @(negedge clk);
        end
        check("b2b_fall_period", fall, DONE_A + 1);
        check("b2b_ready_low", ok, 1);
        valid_a = 1'b0;
        done_n  = -1;
        for (int n = 101; n < 400 && done_n < 0; n++) begin
            if (m_done) done_n = n;
            else        @(negedge clk);
        end
        check("b2b_second_done", done_n, 2 * DONE_A + 1);

        // Data and valid changes while busy are ignored.
        send_frame(8'h55, 1'b0, DONE_A, 1'b1);
        ok = 1'b1;
        repeat (20) begin
            if (m_serial !== 1'b1 || m_ready !== 1'b1 || m_done !== 1'b0 || m_busy !== 1'b0)
                ok = 1'b0;
            @(negedge clk);
        end
        check("no_frame_after_disturb", ok, 1);

        // An asynchronous reset during data bit 3 aborts the frame immediately.
        wait_ready("abort_ready");
        @(negedge clk);
        tx_data = 8'h5A;
        valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        repeat (36) @(negedge clk);
        check("abort_mid_bit3_line", m_serial, 1'b1);   // data bit 3 of 0x5A is 1
        #2 reset = 1'b1;
        #1;
        check("abort_async_outputs", {m_serial, m_busy, m_done, m_ready}, 4'b1001);
        ok = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (m_done !== 1'b0) ok = 1'b0;
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (m_done !== 1'b0 || m_serial !== 1'b1) ok = 1'b0;
        end
        check("abort_no_done", ok, 1);
        send_frame(8'h81, 1'b0, DONE_A, 1'b0);

        // The two-stop-bit instance.
        sel = 1'b1;
        send_frame(8'hF0, 1'b0, DONE_B, 1'b0);
        sel = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
